// File: rtl/rf_dump.sv
// Register-file dump initiator: walks FIRST_REG..LAST_REG on a dedicated read port
// and presents each captured value as an {address, data} valid/ready beat.
module rf_dump #(
    parameter int A_WIDTH   = 5,
    parameter int D_WIDTH   = 32,
    parameter int FIRST_REG = 0,
    parameter int LAST_REG  = 31
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    output logic [A_WIDTH-1:0] rd_addr,
    input  logic [D_WIDTH-1:0] rd_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [A_WIDTH-1:0] out_addr,
    output logic [D_WIDTH-1:0] out_data,
    output logic               busy,
    output logic               done
);

    localparam logic [A_WIDTH-1:0] FIRST = A_WIDTH'(FIRST_REG);
    localparam logic [A_WIDTH-1:0] LAST  = A_WIDTH'(LAST_REG);

    typedef enum logic [1:0] {IDLE, READ, PRESENT, FINISH} state_t;

    state_t state;

    // rd_addr doubles as the walk index; out_addr mirrors it while a beat is
    // presented, so termination compares out_addr against LAST and never wraps.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            rd_addr   <= FIRST;
            out_addr  <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    rd_addr <= FIRST;
                    if (start) begin
                        state <= READ;
                        busy  <= 1'b1;
                    end
                end
                READ: begin
                    out_data  <= rd_data;
                    out_addr  <= rd_addr;
                    out_valid <= 1'b1;
                    state     <= PRESENT;
                end
                PRESENT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (out_addr == LAST) begin
                            state   <= FINISH;
                            done    <= 1'b1;
                            rd_addr <= FIRST;
                        end else begin
                            state   <= READ;
                            rd_addr <= out_addr + 1'b1;
                        end
                    end
                end
                FINISH: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rf_dump.sv
// Directed bench for rf_dump: a full-range instance plus a single-register
// instance (FIRST_REG = LAST_REG = 10) sharing one register-file model.
module tb_rf_dump;

    localparam int AW = 5;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          out_ready;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;
    logic          out_valid;
    logic [AW-1:0] out_addr;
    logic [DW-1:0] out_data;
    logic          busy;
    logic          done;

    logic          s_start;
    logic          s_ready;
    logic [AW-1:0] s_rd_addr;
    logic [DW-1:0] s_rd_data;
    logic          s_valid;
    logic [AW-1:0] s_addr;
    logic [DW-1:0] s_data;
    logic          s_busy;
    logic          s_done;

    logic [DW-1:0] regs [32];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign rd_data   = regs[rd_addr];
    assign s_rd_data = regs[s_rd_addr];

    rf_dump #(.A_WIDTH(AW), .D_WIDTH(DW), .FIRST_REG(0), .LAST_REG(31)) dut (
        .clk(clk), .rst(rst), .start(start), .rd_addr(rd_addr), .rd_data(rd_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr),
        .out_data(out_data), .busy(busy), .done(done)
    );

    rf_dump #(.A_WIDTH(AW), .D_WIDTH(DW), .FIRST_REG(10), .LAST_REG(10)) u_single (
        .clk(clk), .rst(rst), .start(s_start), .rd_addr(s_rd_addr), .rd_data(s_rd_data),
        .out_valid(s_valid), .out_ready(s_ready), .out_addr(s_addr),
        .out_data(s_data), .busy(s_busy), .done(s_done)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic preload();
        regs[0] = '0;
        for (int i = 1; i < 32; i++) regs[i] = 32'(256 + i);
    endtask

    function automatic logic [DW-1:0] exp_data(input int i);
        return (i == 0) ? '0 : 32'(256 + i);
    endfunction

    task automatic wait_beat(input logic [AW-1:0] addr, output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 200; n++) begin
            if (out_valid && out_addr == addr) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 200; n++) begin
            if (done) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; out_ready = 1'b0; s_start = 1'b0; s_ready = 1'b0;
        preload();
        tick();
        tick();
        checks++; if (rd_addr !== 5'd0) begin errors++; $display("[TB] FAIL reset_rd_addr got %0h exp 0", rd_addr); end
        checks++; if (out_addr !== 5'd0) begin errors++; $display("[TB] FAIL reset_out_addr got %0h exp 0", out_addr); end
        checks++; if (out_data !== 32'd0) begin errors++; $display("[TB] FAIL reset_out_data got %0h exp 0", out_data); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid got %0h exp 0", out_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got %0h exp 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done got %0h exp 0", done); end
        checks++; if (s_rd_addr !== 5'd10) begin errors++; $display("[TB] FAIL reset_single_rd_addr got %0h exp a", s_rd_addr); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_full_dump();
        int beats = 0;
        out_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int cyc = 1; cyc <= 68; cyc++) begin
            checks++; if (busy !== (cyc <= 65)) begin errors++; $display("[TB] FAIL full_busy cyc %0d got %0h exp %0h", cyc, busy, (cyc <= 65)); end
            checks++; if (done !== (cyc == 65)) begin errors++; $display("[TB] FAIL full_done cyc %0d got %0h exp %0h", cyc, done, (cyc == 65)); end
            checks++; if (out_valid !== (cyc >= 2 && cyc <= 64 && cyc % 2 == 0)) begin errors++; $display("[TB] FAIL full_valid cyc %0d got %0h", cyc, out_valid); end
            if (out_valid) begin
                checks++;
                if (out_addr !== AW'(beats) || out_data !== exp_data(beats)) begin
                    errors++; $display("[TB] FAIL full_beat got %0h/%0h exp %0h/%0h", out_addr, out_data, beats, exp_data(beats));
                end
                beats++;
            end
            tick();
        end
        checks++; if (beats != 32) begin errors++; $display("[TB] FAIL full_beat_count got %0d exp 32", beats); end
    endtask

    task automatic test_stall();
        int beats = 0;
        int stall = 0;
        bit tog = 1'b1;
        bit held = 1'b0;
        bit got_done = 1'b0;
        logic [AW-1:0] h_addr = '0;
        logic [DW-1:0] h_data = '0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int n = 0; n < 400 && !got_done; n++) begin
            if (held) begin
                checks++;
                if (out_valid !== 1'b1 || out_addr !== h_addr || out_data !== h_data) begin
                    errors++; $display("[TB] FAIL stall_hold got %0h/%0h/%0h exp 1/%0h/%0h", out_valid, out_addr, out_data, h_addr, h_data);
                end
            end
            if (done) got_done = 1'b1;
            if (out_valid && out_addr == 5'd10 && stall < 5) begin
                out_ready = 1'b0;
                stall++;
            end else begin
                out_ready = tog;
            end
            tog = ~tog;
            held = 1'b0;
            if (out_valid) begin
                if (out_ready) begin
                    checks++;
                    if (out_addr !== AW'(beats) || out_data !== exp_data(beats)) begin
                        errors++; $display("[TB] FAIL stall_beat got %0h/%0h exp %0h/%0h", out_addr, out_data, beats, exp_data(beats));
                    end
                    beats++;
                end else begin
                    held = 1'b1; h_addr = out_addr; h_data = out_data;
                end
            end
            tick();
        end
        out_ready = 1'b1;
        checks++; if (!got_done) begin errors++; $display("[TB] FAIL stall_done got 0 exp 1"); end
        checks++; if (beats != 32) begin errors++; $display("[TB] FAIL stall_beat_count got %0d exp 32", beats); end
        checks++; if (stall != 5) begin errors++; $display("[TB] FAIL stall_len got %0d exp 5", stall); end
        tick();
    endtask

    task automatic test_snapshot();
        bit ok;
        out_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_beat(5'd5, ok);
        out_ready = 1'b0;
        checks++; if (!ok) begin errors++; $display("[TB] FAIL snap_reach5 got 0 exp 1"); end
        regs[5] = 32'hDEAD;
        regs[6] = 32'hBEEF;
        tick();
        tick();
        checks++; if (out_addr !== 5'd5 || out_data !== 32'h105) begin errors++; $display("[TB] FAIL snap_beat5 got %0h/%0h exp 5/105", out_addr, out_data); end
        out_ready = 1'b1;
        tick();
        tick();
        checks++; if (out_valid !== 1'b1 || out_addr !== 5'd6 || out_data !== 32'hBEEF) begin errors++; $display("[TB] FAIL snap_beat6 got %0h/%0h/%0h exp 1/6/beef", out_valid, out_addr, out_data); end
        wait_done(ok);
        checks++; if (!ok) begin errors++; $display("[TB] FAIL snap_done got 0 exp 1"); end
        tick();
        preload();
    endtask

    task automatic test_reset_mid();
        bit ok;
        out_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_beat(5'd12, ok);
        checks++; if (!ok) begin errors++; $display("[TB] FAIL rstmid_reach12 got 0 exp 1"); end
        out_ready = 1'b0;
        rst = 1'b1;
        start = 1'b1;
        tick();
        rst = 1'b0;
        start = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_valid got %0h exp 0", out_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_busy got %0h exp 0", busy); end
        checks++; if (rd_addr !== 5'd0) begin errors++; $display("[TB] FAIL rstmid_rd_addr got %0h exp 0", rd_addr); end
        for (int i = 0; i < 3; i++) begin
            checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_idle got %0h/%0h exp 0/0", done, busy); end
            tick();
        end
        out_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        checks++; if (out_valid !== 1'b1 || out_addr !== 5'd0 || out_data !== 32'd0) begin errors++; $display("[TB] FAIL rstmid_restart got %0h/%0h/%0h exp 1/0/0", out_valid, out_addr, out_data); end
        wait_done(ok);
        checks++; if (!ok) begin errors++; $display("[TB] FAIL rstmid_done got 0 exp 1"); end
        tick();
    endtask

    task automatic test_busy_start();
        bit ok;
        bit got_done = 1'b0;
        int next = 4;
        out_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_beat(5'd3, ok);
        checks++; if (!ok) begin errors++; $display("[TB] FAIL busy_reach3 got 0 exp 1"); end
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int n = 0; n < 100; n++) begin
            if (done) begin
                got_done = 1'b1;
                break;
            end
            if (out_valid) begin
                checks++; if (out_addr !== AW'(next)) begin errors++; $display("[TB] FAIL busy_seq got %0h exp %0h", out_addr, next); end
                next++;
            end
            tick();
        end
        checks++; if (!got_done || next != 32) begin errors++; $display("[TB] FAIL busy_complete got %0h/%0d exp 1/32", got_done, next); end
        tick();
        tick();
        checks++; if (busy !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("[TB] FAIL busy_no_restart got %0h/%0h exp 0/0", busy, out_valid); end
    endtask

    task automatic test_start_held();
        bit ok;
        int gap = 0;
        out_ready = 1'b1;
        start = 1'b1;
        tick();
        wait_done(ok);
        checks++; if (!ok) begin errors++; $display("[TB] FAIL held_first_done got 0 exp 1"); end
        for (int n = 0; n < 10; n++) begin
            tick();
            gap++;
            if (out_valid) break;
        end
        checks++; if (gap != 3) begin errors++; $display("[TB] FAIL held_gap got %0d exp 3", gap); end
        start = 1'b0;
        wait_done(ok);
        checks++; if (!ok) begin errors++; $display("[TB] FAIL held_second_done got 0 exp 1"); end
        tick();
    endtask

    task automatic test_single();
        regs[10] = 32'h1234;
        s_ready = 1'b1;
        s_start = 1'b1;
        tick();
        s_start = 1'b0;
        checks++; if (s_busy !== 1'b1 || s_valid !== 1'b0 || s_rd_addr !== 5'd10) begin errors++; $display("[TB] FAIL single_read got %0h/%0h/%0h exp 1/0/a", s_busy, s_valid, s_rd_addr); end
        tick();
        checks++; if (s_valid !== 1'b1 || s_addr !== 5'd10 || s_data !== 32'h1234 || s_done !== 1'b0) begin errors++; $display("[TB] FAIL single_beat got %0h/%0h/%0h/%0h exp 1/a/1234/0", s_valid, s_addr, s_data, s_done); end
        tick();
        checks++; if (s_done !== 1'b1 || s_valid !== 1'b0 || s_busy !== 1'b1) begin errors++; $display("[TB] FAIL single_finish got %0h/%0h/%0h exp 1/0/1", s_done, s_valid, s_busy); end
        tick();
        checks++; if (s_done !== 1'b0 || s_busy !== 1'b0) begin errors++; $display("[TB] FAIL single_idle got %0h/%0h exp 0/0", s_done, s_busy); end
    endtask

    initial begin
        test_reset();
        test_full_dump();
        test_stall();
        test_snapshot();
        test_reset_mid();
        test_busy_start();
        test_start_held();
        test_single();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog got timeout exp finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/rf_dump.md
Name: rf_dump

Overview:
- Read-side initiator for the processor register file: on a start request it drives a read address, walks registers FIRST_REG..LAST_REG in order, and captures each value.
- Each captured value is presented downstream as an {address, data} beat using a valid/ready handshake, for debug/trace (UART or testbench monitor).
- Sits beside the core on a dedicated register-file read port. It never writes the register file.

Parameters:
- A_WIDTH, 5, register address width.
- D_WIDTH, 32, register data width.
- FIRST_REG, 0, first register index dumped.
- LAST_REG, 31, last register index dumped. Must satisfy FIRST_REG <= LAST_REG <= 2**A_WIDTH-1.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  dump request; sampled only in IDLE.
- rd_addr  out  A_WIDTH  read address to the register-file read port.
- rd_data  in  D_WIDTH  combinational read data for rd_addr.
- out_valid  out  1  beat valid.
- out_ready  in  1  downstream accept.
- out_addr  out  A_WIDTH  register index of the current beat.
- out_data  out  D_WIDTH  captured register value of the current beat.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse after the final beat is accepted.

Behaviour:
- Reset values:
  - State = IDLE.
  - rd_addr = FIRST_REG; out_addr = 0; out_data = 0.
  - out_valid = 0; busy = 0; done = 0.
- FSM states: IDLE, READ, PRESENT, FINISH.
- IDLE:
  - start=1 -> READ, with index set to FIRST_REG.
  - Otherwise remain in IDLE. rd_addr holds FIRST_REG.
- READ (exactly 1 cycle):
  - rd_addr = index.
  - At the posedge, out_data <= rd_data and out_addr <= index; -> PRESENT.
- PRESENT:
  - out_valid = 1. out_addr and out_data are held stable until the handshake.
  - Handshake occurs on a posedge with out_valid && out_ready.
  - On handshake with index == LAST_REG -> FINISH.
  - On handshake with index < LAST_REG -> index + 1, -> READ.
  - No handshake: stay in PRESENT indefinitely; no timeout.
- FINISH (1 cycle): done = 1, out_valid = 0; -> IDLE.
- Latency:
  - start to first out_valid: 2 cycles.
  - With out_ready tied high, each beat takes 2 cycles.
  - Full dump of N registers = 2N + 1 cycles from start to the done pulse.
- Snapshot semantics:
  - out_data is the register value at the READ-cycle posedge.
  - Register-file writes after that edge do not alter a beat already captured.
  - A dump is not an atomic snapshot across registers.
- Register x0 is dumped like any other register. Its value is whatever the port returns (0 in this design).
- start while busy is ignored: no queuing, no restart.
- start held high continuously: a new dump begins in the cycle after FINISH (IDLE sees start).
- Index arithmetic:
  - index is A_WIDTH bits and is never incremented past LAST_REG, so there is no wrap-around.
  - With LAST_REG = 2**A_WIDTH-1, termination is by compare, not by overflow.
- out_ready is ignored outside PRESENT.
- Reset mid-dump:
  - Abort immediately to the reset values above. No done pulse; a pending beat is dropped.
  - rst has priority over start in the same cycle.
- FIRST_REG == LAST_REG: a single beat, then FINISH.

Test Plan:
- Preload x1..x31 with 0x100+i; pulse start; out_ready=1 -> 32 beats, addr 0..31, data 0, 0x101..0x11F; done pulses at cycle 65 after start; busy high cycles 1..65.
- Same preload, out_ready toggling 1/0 every cycle and a 5-cycle stall at addr 10 -> out_addr/out_data stable during every stall; no beat lost or duplicated; 32 beats total.
- During PRESENT of addr 5 (data 0x105), write x5=0xDEAD and x6=0xBEEF -> beat 5 still shows 0x105; beat 6 shows 0xBEEF.
- Assert rst while in PRESENT at addr 12 -> next cycle out_valid=0, busy=0, rd_addr=0, no done; a following start restarts at addr 0.
- Pulse start while busy at addr 3 -> ignored, dump completes normally. start held high -> second dump's first out_valid appears 3 cycles after the first done.
- Parameters FIRST_REG=10, LAST_REG=10, x10=0x1234 -> exactly one beat {10, 0x1234}; done 1 cycle after its handshake.
